// File: rtl/modmul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : modmul_rr_sched (with helper modred_v2)
// Desc     : Round-robin arbiter in front of a 3-stage (a*b) mod (2^(LOGQ-1)+1)
//            pipeline with result backpressure and requester tagging.
// Options  : define MODMUL_RR_SCHED_CNT_EN to add the 32-bit op_count output.
// Revision : 1.0 - initial release
// ============================================================================

module modred_v2 #(
    parameter int LOGQ = 17
) (
    input  logic [2*LOGQ-1:0] x_i,
    output logic [LOGQ-1:0]   r_o
);

    localparam int N  = LOGQ - 1;
    localparam int TW = LOGQ + 2;
    localparam logic [TW-1:0] Q_W = TW'((64'd1 << N) + 64'd1);

    logic [N-1:0]  c0;
    logic [N-1:0]  c1;
    logic [1:0]    c2;
    logic [TW-1:0] t0;
    logic [TW-1:0] t1;

    // 2^N == -1 mod Q, so x mod Q is the alternating sum of N-bit chunks.
    // The product never exceeds 2N+2 bits, leaving only a 2-bit top chunk.
    assign c0 = x_i[N-1:0];
    assign c1 = x_i[2*N-1:N];
    assign c2 = x_i[2*LOGQ-1:2*N];

    // Adding Q keeps t0 non-negative; t0 lies in [2, 2Q+1], hence two folds.
    assign t0  = TW'(c0) + TW'(c2) + Q_W - TW'(c1);
    assign t1  = (t0 >= Q_W) ? (t0 - Q_W) : t0;
    assign r_o = LOGQ'((t1 >= Q_W) ? (t1 - Q_W) : t1);

endmodule

module modmul_rr_sched #(
    parameter int LOGQ = 17,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LOGQ-1:0] op_a,
    input  logic [NREQ*LOGQ-1:0] op_b,
    output logic [NREQ-1:0]      gnt,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [LOGQ-1:0]      res,
    input  logic                 res_ready,
    output logic                 busy
`ifdef MODMUL_RR_SCHED_CNT_EN
    ,
    output logic [31:0]          op_count
`endif
);

    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    ptr_d;
    logic              v1_q;
    logic              v2_q;
    logic              v3_q;
    logic [LOGQ-1:0]   a1_q;
    logic [LOGQ-1:0]   b1_q;
    logic [IDW-1:0]    id1_q;
    logic [IDW-1:0]    id2_q;
    logic [IDW-1:0]    id3_q;
    logic [2*LOGQ-1:0] prod2_q;
    logic [2*LOGQ-1:0] prod_d;
    logic [LOGQ-1:0]   res_q;
    logic [LOGQ-1:0]   red_d;

    logic              stall;
    logic              found;
    logic              grant;
    logic [IDW-1:0]    win;
    logic [LOGQ-1:0]   sel_a;
    logic [LOGQ-1:0]   sel_b;

    assign stall = v3_q & ~res_ready;

    // Two passes: first requesters at or above ptr, then the wrapped ones.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (IDW'(j) >= ptr_q)) begin
                found = 1'b1;
                win   = IDW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IDW'(j);
            end
        end
    end

    assign grant = found & ~stall & ~rst;

    always_comb begin
        gnt   = '0;
        sel_a = '0;
        sel_b = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (win == IDW'(j)) begin
                gnt[j] = grant;
                sel_a  = op_a[j*LOGQ +: LOGQ];
                sel_b  = op_b[j*LOGQ +: LOGQ];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (win == IDW'(NREQ - 1)) ? '0 : (win + IDW'(1));
        end
    end

    assign prod_d = (2*LOGQ)'(a1_q) * (2*LOGQ)'(b1_q);

    modred_v2 #(
        .LOGQ (LOGQ)
    ) u_modred (
        .x_i (prod2_q),
        .r_o (red_d)
    );

    // Whole pipeline moves as one; a stall freezes every stage including ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            id1_q   <= '0;
            id2_q   <= '0;
            id3_q   <= '0;
            prod2_q <= '0;
            res_q   <= '0;
        end else if (!stall) begin
            ptr_q <= ptr_d;
            v1_q  <= grant;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            if (grant) begin
                a1_q  <= sel_a;
                b1_q  <= sel_b;
                id1_q <= win;
            end
            if (v1_q) begin
                prod2_q <= prod_d;
                id2_q   <= id1_q;
            end
            if (v2_q) begin
                res_q <= red_d;
                id3_q <= id2_q;
            end
        end
    end

    assign res       = res_q;
    assign res_id    = id3_q;
    assign res_valid = v3_q;
    assign busy      = v1_q | v2_q | v3_q;

`ifdef MODMUL_RR_SCHED_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (grant) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign op_count = cnt_q;
`else
    // Acceptance counter not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_modmul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_modmul_rr_sched
// Desc     : Directed scoreboard bench for modmul_rr_sched (LOGQ=17, NREQ=4).
//            Checks op_count as well when MODMUL_RR_SCHED_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

module tb_modmul_rr_sched;

    localparam int LOGQ = 17;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*LOGQ-1:0] op_a = '0;
    logic [NREQ*LOGQ-1:0] op_b = '0;
    logic [NREQ-1:0]      gnt;
    logic                 res_valid;
    logic [IDW-1:0]       res_id;
    logic [LOGQ-1:0]      res;
    logic                 res_ready = 1'b1;
    logic                 busy;
`ifdef MODMUL_RR_SCHED_CNT_EN
    logic [31:0]          op_count;
`endif

    modmul_rr_sched #(
        .LOGQ (LOGQ),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res       (res),
        .res_ready (res_ready),
        .busy      (busy)
`ifdef MODMUL_RR_SCHED_CNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IDW+LOGQ-1:0] sbq[$];

    int              cyc        = 0;
    int              last_pop   = -10;
    int              streak     = 0;
    int              max_streak = 0;
    logic            prev_stall = 1'b0;
    logic [LOGQ-1:0] held_res   = '0;
    logic [IDW-1:0]  held_id    = '0;

    // Products hand-reduced mod 65537 for requesters 0..3.
    logic [LOGQ-1:0] t3_exp[4] = '{17'd24463, 17'd16945, 17'd65531, 17'd25598};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b);
        op_a[i*LOGQ +: LOGQ] = a;
        op_b[i*LOGQ +: LOGQ] = b;
    endtask

    task automatic set_t3_ops();
        set_op(0, 17'd300,   17'd300);
        set_op(1, 17'd1000,  17'd1000);
        set_op(2, 17'd65535, 17'd3);
        set_op(3, 17'd50000, 17'd50000);
    endtask

    // One cycle from a negedge: drive, check grant, queue the expected result.
    task automatic step(input logic [NREQ-1:0] r, input logic rdy, input int k,
                        input logic [LOGQ-1:0] er);
        logic [NREQ-1:0] eg;
        req       = r;
        res_ready = rdy;
        #1;
        eg = '0;
        if (k >= 0) eg[k] = 1'b1;
        chk("gnt", gnt, eg);
        if (k >= 0) sbq.push_back({IDW'(k), er});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
    endtask

    task automatic drain();
        int t;
        t         = 0;
        req       = '0;
        res_ready = 1'b1;
        while ((sbq.size() != 0 || busy) && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue", sbq.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    // Monitor: samples 2 time units after each negedge, after the driver.
    initial begin
        logic [IDW+LOGQ-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("res_hold", res, held_res);
                chk("res_id_hold", res_id, held_id);
            end
            if (res_valid && res_ready) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got id=%0d res=%0d, expected no result", res_id, res);
                end else begin
                    e = sbq.pop_front();
                    chk("res_id", res_id, e[IDW+LOGQ-1:LOGQ]);
                    chk("res", res, e[LOGQ-1:0]);
                end
                streak   = (last_pop == cyc - 1) ? streak + 1 : 1;
                last_pop = cyc;
                if (streak > max_streak) max_streak = streak;
            end
            prev_stall = res_valid && !res_ready;
            held_res   = res;
            held_id    = res_id;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);

        // Test 1: Q-1 squared, single requester, latency 3
        do_reset();
        chk("rst_res", res, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_valid_after", res_valid, 0);
        set_op(2, 17'd65536, 17'd65536);
        step(4'b0100, 1'b1, 2, 17'd1);
        req = '0;
        #1;
        chk("busy_active", busy, 1);
        chk("lat_cycle1", res_valid, 0);
        @(negedge clk);
        #1;
        chk("lat_cycle2", res_valid, 0);
        @(negedge clk);
        #1;
        chk("lat_cycle3", res_valid, 1);
        @(negedge clk);
        drain();

        // Test 2: back-to-back from one requester, zero operand
        do_reset();
        max_streak = 0;
        set_op(0, 17'd12345, 17'd2);
        step(4'b0001, 1'b1, 0, 17'd24690);
        set_op(0, 17'd0, 17'd40000);
        step(4'b0001, 1'b1, 0, 17'd0);
        drain();
        chk("t2_back_to_back", max_streak, 2);

        // Test 3: all requesting, pointer wraps, gapless return
        do_reset();
        set_t3_ops();
        max_streak = 0;
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, i % 4, t3_exp[i % 4]);
        drain();
        chk("t3_gapless", max_streak, 8);

        // Test 4: stall with three in flight
        do_reset();
        set_op(0, 17'd7,     17'd9);
        set_op(1, 17'd256,   17'd256);
        set_op(2, 17'd4096,  17'd32);
        set_op(3, 17'd65536, 17'd2);
        step(4'b0001, 1'b0, 0, 17'd63);
        step(4'b0010, 1'b0, 1, 17'd65536);
        step(4'b0100, 1'b0, 2, 17'd65535);
        step(4'b1000, 1'b0, -1, 17'd0);
        chk("t4_busy_stall", busy, 1);
        step(4'b1000, 1'b0, -1, 17'd0);
        step(4'b1000, 1'b1, 3, 17'd65535);
        drain();

        // Test 5: reset mid-flight discards everything, ptr restarts
        do_reset();
        set_op(0, 17'd7,     17'd9);
        set_op(1, 17'd256,   17'd256);
        set_op(2, 17'd4096,  17'd32);
        set_op(3, 17'd65536, 17'd2);
        step(4'b0001, 1'b0, 0, 17'd63);
        step(4'b0010, 1'b0, 1, 17'd65536);
        step(4'b0100, 1'b0, 2, 17'd65535);
        #1;
        chk("t5_valid_before_rst", res_valid, 1);
        @(negedge clk);
        req = 4'b1111;
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b1, -1, 17'd0);
        chk("t5_no_stale", res_valid, 0);
        step(4'b0010, 1'b1, 1, 17'd65536);
        step(4'b1011, 1'b1, 3, 17'd65535);
        drain();

`ifdef MODMUL_RR_SCHED_CNT_EN
        // Test 6: acceptance counter across a stall and reset
        do_reset();
        set_t3_ops();
        step(4'b1111, 1'b0, 0, t3_exp[0]);
        step(4'b1111, 1'b0, 1, t3_exp[1]);
        step(4'b1111, 1'b0, 2, t3_exp[2]);
        step(4'b1111, 1'b0, -1, 17'd0);
        step(4'b1111, 1'b0, -1, 17'd0);
        #1;
        chk("cnt_stall_hold", op_count, 3);
        step(4'b1111, 1'b1, 3, t3_exp[3]);
        step(4'b1111, 1'b1, 0, t3_exp[0]);
        step(4'b1111, 1'b1, 1, t3_exp[1]);
        step(4'b1111, 1'b1, 2, t3_exp[2]);
        step(4'b1111, 1'b1, 3, t3_exp[3]);
        step(4'b1111, 1'b1, 0, t3_exp[0]);
        step(4'b1111, 1'b1, 1, t3_exp[1]);
        drain();
        chk("cnt_total", op_count, 10);
        do_reset();
        chk("cnt_reset", op_count, 0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/modmul_rr_sched.md
Name: modmul_rr_sched

Overview:
- Round-robin scheduler that shares one pipelined modular multiplier among NREQ requesters, typically butterfly and twiddle-update units in the NTT core.
- Computes (a*b) mod Q, with Q = 2^(LOGQ-1)+1, and returns each result tagged with the requester index.
- The reduction stage instantiates the existing modred_v2 unit; this block supplies arbitration, the pipeline registers and backpressure handling.

Parameters:
- LOGQ, 17, operand/result width; Q = 2^(LOGQ-1)+1.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of the result tag; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock; all flops rise-edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; held high with operands stable until granted.
- op_a  in  NREQ*LOGQ  flattened operand A; requester i occupies bits [i*LOGQ +: LOGQ]; value < Q.
- op_b  in  NREQ*LOGQ  flattened operand B, same layout; value < Q.
- gnt  out  NREQ  one-hot combinational grant; req[i]&gnt[i] is the acceptance cycle.
- res_valid  out  1  result available.
- res_id  out  IDW  index of the requester owning the result.
- res  out  LOGQ  (a*b) mod Q, in the range 0..Q-1.
- res_ready  in  1  downstream accepts the result.
- busy  out  1  high while any pipeline stage holds a valid entry.

Behaviour:
- Reset, asynchronous:
  - Stage valid bits v1/v2/v3 = 0; round-robin pointer ptr = 0.
  - res = 0, res_id = 0, res_valid = 0, busy = 0.
  - gnt = 0 while rst is high.
- Stall: stall = v3 & ~res_ready.
  - During stall, every pipeline register holds its value and gnt = 0.
  - res and res_id stay stable while res_valid & ~res_ready.
- Arbitration (when not stalled):
  - Scan req from index ptr upward, wrapping modulo NREQ.
  - The first set bit k receives gnt[k] = 1; at most one grant per cycle.
  - After a grant, ptr <= (k+1) mod NREQ. With no request, ptr holds.
- Stage 1 (acceptance edge):
  - Latch a_k, b_k, id = k.
  - v1 <= 1 if a grant occurred, else v1 <= 0.
- Stage 2: register the full 2*LOGQ-bit product a*b.
  - No truncation; maximum product is (Q-1)^2 < 2^(2*LOGQ).
- Stage 3: register the modred_v2 output as res, carry id through as res_id; res_valid = v3.
- Latency and throughput:
  - Exactly 3 cycles from the acceptance edge to res_valid when there is no stall.
  - Throughput is 1 result per cycle.
  - Stalls add latency cycle-for-cycle.
- Result order is acceptance order; no reordering.
- A result leaves on res_valid & res_ready. The pipeline advances in that same cycle, so a new grant may issue.
- busy = v1 | v2 | v3.
- Boundary conditions:
  - Operand Q-1 times Q-1 gives 1.
  - Either operand 0 gives 0.
  - The pointer wraps from NREQ-1 to 0.
  - A single continuous requester is granted every cycle.
- Requester dropping req without a grant: allowed; nothing is enqueued.
- Reset asserted mid-operation:
  - All in-flight operations are discarded.
  - res_valid falls immediately (asynchronously).
  - No stale result appears after release; ptr restarts at 0.
- Operands >= Q: result undefined; the bench must not drive them.

Optional Feature:
- Macro: MODMUL_RR_SCHED_CNT_EN.
- Defined:
  - Adds output port op_count, 32 bits.
  - It is reset to 0 and increments once per acceptance (any gnt with its req).
  - It wraps at 2^32 and is held during stall.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
1. LOGQ=17 (Q=65537), NREQ=4, only req[2] with a=65536, b=65536, res_ready=1 -> gnt=4'b0100 one cycle; 3 cycles later res_valid=1, res=1, res_id=2.
2. req[0] with a=12345, b=2, then a=0, b=40000 on the following cycle -> res=24690 then res=0, on consecutive cycles, res_id=0 both.
3. All req=4'b1111 held for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; results return in the same order with no gaps.
4. Three operations in flight, res_ready=0 for 2 cycles -> gnt=0 and res/res_id stable while stalled; after res_ready=1, all three results arrive in order with none lost or duplicated.
5. Three operations in flight, rst pulsed for 1 cycle -> res_valid=0 and busy=0 immediately; no results afterwards; the next req[1] alone is granted, then ptr=2.
6. MODMUL_RR_SCHED_CNT_EN defined, 10 accepted operations including a 2-cycle stall -> op_count=10; after rst, op_count=0.
